shift_exec_unit: RTL and testbench

- Execute-stage issue/retire wrapper that sits directly upstream of the combinational barrelshifter32.
- Takes decoded MIPS R-type shift instructions (sll/srl/sra/sllv/srlv/srav) and selects the shift amount from shamt or rs[4:0].
- Generates the 2-bit aluc code, drives barrelshifter32, and registers its output toward write-back.
- Two-stage elastic pipeline: valid/ready on both sides, 1 op/cycle throughput, flush support, retired-op counter.

---
 rtl/mips_pkg.sv | 18 +
 rtl/barrelshifter32.sv | 32 +++
 rtl/shift_exec_unit.sv | 128 ++++++++++++
 tb/tb_shift_exec_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: R-type shift funct codes and the barrel shifter aluc codes.
// No logic, constants only.
// Used by the shift execute unit and the barrel shifter.
package mips_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  localparam logic [1:0] ALUC_SLA = 2'b00;
  localparam logic [1:0] ALUC_SRL = 2'b01;
  localparam logic [1:0] ALUC_SLL = 2'b10;
  localparam logic [1:0] ALUC_SRA = 2'b11;

endpackage

// File: rtl/barrelshifter32.sv
// 32-bit barrel shifter: left (sla/sll), logical right (srl), arithmetic right (sra).
// Latency: purely combinational.
// Backpressure: none, no state.
module barrelshifter32
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [4:0]  b,
  input  logic [1:0]  aluc,
  output logic [31:0] c
);

  logic        right;
  logic        fill;
  logic [5:0][31:0] stg;

  // Both left encodings (sla, sll) shift the same way; only sra fills with the sign.
  assign right  = (aluc == ALUC_SRL) || (aluc == ALUC_SRA);
  assign fill   = (aluc == ALUC_SRA) & a[31];
  assign stg[0] = a;

  // Five log-stages: stage k shifts by 2**k when b[k] is set.
  for (genvar k = 0; k < 5; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign stg[k+1] = !b[k] ? stg[k] :
                      right ? {{SH{fill}}, stg[k][31:SH]} :
                              {stg[k][31-SH:0], {SH{1'b0}}};
  end

  assign c = stg[5];

endmodule

// File: rtl/shift_exec_unit.sv
// Execute-stage wrapper for MIPS R-type shifts: decode, S1 operand register, barrel shift, S2 result register.
// Latency: 2 cycles from input handshake to out_valid; 1 op/cycle sustained.
// Backpressure: valid/ready elastic; a stage loads when it is empty or the stage after it drains.
module shift_exec_unit
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_funct,
  input  logic [4:0]       in_shamt,
  input  logic [31:0]      in_rs,
  input  logic [31:0]      in_rt,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_rd,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  logic [4:0]  dec_b;
  logic [1:0]  dec_aluc;
  logic        dec_err;

  logic        s1_valid, s1_err;
  logic [31:0] s1_a;
  logic [4:0]  s1_b, s1_rd;
  logic [1:0]  s1_aluc;

  logic        s2_valid, s2_err;
  logic [31:0] s2_result;
  logic [4:0]  s2_rd;

  logic        s1_ready, s2_ready;
  logic [31:0] shift_out;
  logic        unused_rs_hi;

  // Only rs[4:0] is a legal shift amount; the upper bits are deliberately dropped.
  assign unused_rs_hi = ^in_rs[31:5];

  // Decode funct into shift amount source and aluc; unknown functs become zero-result error ops.
  always_comb begin
    dec_b    = 5'd0;
    dec_aluc = ALUC_SLL;
    dec_err  = 1'b0;
    case (in_funct)
      FUNCT_SLL:  begin dec_b = in_shamt;   dec_aluc = ALUC_SLL; end
      FUNCT_SRL:  begin dec_b = in_shamt;   dec_aluc = ALUC_SRL; end
      FUNCT_SRA:  begin dec_b = in_shamt;   dec_aluc = ALUC_SRA; end
      FUNCT_SLLV: begin dec_b = in_rs[4:0]; dec_aluc = ALUC_SLL; end
      FUNCT_SRLV: begin dec_b = in_rs[4:0]; dec_aluc = ALUC_SRL; end
      FUNCT_SRAV: begin dec_b = in_rs[4:0]; dec_aluc = ALUC_SRA; end
      default:    dec_err = 1'b1;
    endcase
  end

  assign s2_ready = !s2_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;

  // S1: capture decoded operands; flush drops any op, including one accepted this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_aluc  <= ALUC_SLL;
      s1_rd    <= '0;
      s1_err   <= 1'b0;
    end else begin
      if (flush)         s1_valid <= 1'b0;
      else if (s1_ready) s1_valid <= in_valid;
      if (in_valid && s1_ready) begin
        s1_a    <= in_rt;
        s1_b    <= dec_b;
        s1_aluc <= dec_aluc;
        s1_rd   <= in_rd;
        s1_err  <= dec_err;
      end
    end
  end

  barrelshifter32 u_shifter (
    .a    (s1_a),
    .b    (s1_b),
    .aluc (s1_aluc),
    .c    (shift_out)
  );

  // S2: register shifter output toward write-back; held stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_rd     <= '0;
      s2_err    <= 1'b0;
    end else begin
      if (flush)         s2_valid <= 1'b0;
      else if (s2_ready) s2_valid <= s1_valid;
      if (s1_valid && s2_ready) begin
        s2_result <= s1_err ? 32'd0 : shift_out;
        s2_rd     <= s1_rd;
        s2_err    <= s1_err;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_rd     = s2_rd;
  assign out_err    = s2_err;

  // Saturating retire counter; a retire coinciding with flush is treated as killed.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (s2_valid && out_ready && !flush && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_shift_exec_unit.sv
// Self-checking bench for shift_exec_unit: directed scenarios plus randomized traffic
// against a queue-based reference model of in-flight ops.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_shift_exec_unit;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [5:0]    in_funct;
  logic [4:0]    in_shamt, in_rd, out_rd;
  logic [31:0]   in_rs, in_rt, out_result;
  logic [CW-1:0] op_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        err;
    int          age;
  } exp_t;

  exp_t q[$];
  int   cnt_exp = 0;

  shift_exec_unit #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct   (in_funct),
    .in_shamt   (in_shamt),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_err    (out_err),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural meaning of a MIPS shift, straight from the instruction definition.
  function automatic exp_t ref_op(input logic [5:0] f, input logic [4:0] sh,
                                  input logic [31:0] rs, input logic [31:0] rt,
                                  input logic [4:0] rd);
    exp_t e;
    int   amt;
    e.rd  = rd;
    e.err = 1'b0;
    e.age = 0;
    amt   = (f == 6'd4 || f == 6'd6 || f == 6'd7) ? int'(rs % 32) : int'(sh);
    case (f)
      6'd0, 6'd4: e.res = rt << amt;
      6'd2, 6'd6: e.res = rt >> amt;
      6'd3, 6'd7: e.res = $unsigned($signed(rt) >>> amt);
      default: begin e.res = 32'd0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Compare DUT against the model, then advance the model across the coming edge.
  // The oldest op reaches the output two edges after acceptance; two ops in flight means full.
  task automatic monitor();
    logic exp_ov, exp_ir;
    if (rst) begin
      q.delete();
      cnt_exp = 0;
      return;
    end
    exp_ov = (q.size() > 0) && (q[0].age >= 2);
    exp_ir = (q.size() < 2) || out_ready;
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    check("op_count", {28'd0, op_count}, cnt_exp);
    if (exp_ov) begin
      check("out_result", out_result, q[0].res);
      check("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
      check("out_err", {31'd0, out_err}, {31'd0, q[0].err});
    end
    if (flush) begin
      q.delete();
    end else begin
      if (exp_ov && out_ready) begin
        void'(q.pop_front());
        if (cnt_exp < CMAX) cnt_exp++;
      end
      if (in_valid && exp_ir) q.push_back(ref_op(in_funct, in_shamt, in_rs, in_rt, in_rd));
    end
    foreach (q[i]) q[i].age++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
    in_valid = v;
    in_funct = f;
    in_shamt = sh;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
  endtask

  function automatic logic [5:0] rand_funct();
    case ($urandom_range(0, 7))
      0: return 6'd0;
      1: return 6'd2;
      2: return 6'd3;
      3: return 6'd4;
      4: return 6'd6;
      5: return 6'd7;
      default: return 6'($urandom);
    endcase
  endfunction

  task automatic drive_rand();
    drive(1'b1, rand_funct(), 5'($urandom), $urandom, $urandom, 5'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_rd", {27'd0, out_rd}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_op_count", {28'd0, op_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    idle();
    tick();
    do_reset();

    // sra by 15, exact 2-cycle latency
    drive(1'b1, 6'd3, 5'd15, 32'd0, 32'h2A482212, 5'd3);
    tick();
    idle();
    tick();
    check("sra_valid", {31'd0, out_valid}, 32'd1);
    check("sra_result", out_result, 32'h00005490);
    check("sra_err", {31'd0, out_err}, 32'd0);
    tick();

    // sll 4 then srl 12 back-to-back
    do_reset();
    drive(1'b1, 6'd0, 5'd4, 32'd0, 32'h2A482212, 5'd1);
    tick();
    drive(1'b1, 6'd2, 5'd12, 32'd0, 32'h2A482212, 5'd2);
    tick();
    idle();
    check("sll_result", out_result, 32'hA4822120);
    tick();
    check("srl_result", out_result, 32'h0002A482);
    tick();
    check("b2b_op_count", {28'd0, op_count}, 32'd2);

    // variable shifts: amount from rs[4:0] only
    drive(1'b1, 6'd7, 5'd31, 32'h00000024, 32'h80000000, 5'd4);
    tick();
    drive(1'b1, 6'd6, 5'd31, 32'h00000024, 32'h80000000, 5'd5);
    tick();
    idle();
    check("srav_result", out_result, 32'hF8000000);
    tick();
    check("srlv_result", out_result, 32'h08000000);
    tick();

    // backpressure: fill, stall, release
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 6'd0, 5'd1, 32'd0, 32'h00000011, 5'd7);
    tick();
    drive(1'b1, 6'd2, 5'd1, 32'd0, 32'h00000022, 5'd8);
    tick();
    drive(1'b1, 6'd3, 5'd1, 32'd0, 32'h80000044, 5'd9);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    idle();
    repeat (4) tick();
    check("stall_op_count", {28'd0, op_count}, 32'd3);

    // illegal funct
    do_reset();
    drive(1'b1, 6'b100000, 5'd3, 32'h1, 32'hFFFFFFFF, 5'd10);
    tick();
    idle();
    tick();
    check("err_flag", {31'd0, out_err}, 32'd1);
    check("err_result", out_result, 32'd0);
    tick();
    check("err_op_count", {28'd0, op_count}, 32'd1);

    // flush with two ops in flight and a third being offered
    out_ready = 1'b0;
    drive(1'b1, 6'd0, 5'd2, 32'd0, 32'h5, 5'd11);
    tick();
    drive(1'b1, 6'd0, 5'd3, 32'd0, 32'h6, 5'd12);
    tick();
    drive(1'b1, 6'd0, 5'd4, 32'd0, 32'h7, 5'd13);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_op_count", {28'd0, op_count}, 32'd1);
    out_ready = 1'b1;
    repeat (3) tick();

    // saturation of the retire counter
    do_reset();
    repeat (20) begin
      drive_rand();
      tick();
    end
    idle();
    repeat (3) tick();
    check("sat_op_count", {28'd0, op_count}, CMAX);

    // reset in the middle of traffic, together with flush
    repeat (3) begin
      drive_rand();
      tick();
    end
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    idle();
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_op_count", {28'd0, op_count}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);

    // randomized traffic with stalls, flushes and rare resets
    repeat (600) begin
      if ($urandom_range(0, 3) != 0) drive_rand();
      else idle();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    idle();
    repeat (4) tick();
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
